// File: rtl/pet_pkg.sv
// Shared types and saturating level arithmetic for the virtual-pet need engine.
package pet_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE    = 2'd0,
    ST_SLEEPING = 2'd1,
    ST_DEAD     = 2'd2
  } pet_state_e;

  localparam int NEED_HUNGER    = 0;
  localparam int NEED_SLEEP     = 1;
  localparam int NEED_HAPPINESS = 2;
  localparam int NEED_HYGIENE   = 3;
  localparam int NEED_CONDITION = 4;

  // Levels are carried at this width inside the helpers so one function
  // serves any LEVEL_W up to 8; the extra sum bit keeps overflow visible.
  localparam int LVL_W_MAX = 8;
  typedef logic [LVL_W_MAX-1:0] lvl_t;

  function automatic lvl_t sat_inc(input lvl_t level, input lvl_t gain, input lvl_t lim);
    logic [LVL_W_MAX:0] sum;
    sum = {1'b0, level} + {1'b0, gain};
    return (sum > {1'b0, lim}) ? lim : sum[LVL_W_MAX-1:0];
  endfunction

  function automatic lvl_t sat_dec(input lvl_t level);
    return (level == '0) ? '0 : level - 1'b1;
  endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Timebase: prescaler to a tick, then a tick counter to the decay event.
// freeze_i holds both counters so a dead pet stops aging.
module pet_tick_gen #(
  parameter int TICK_DIV    = 50000000,
  parameter int DECAY_TICKS = 900
) (
  input  logic clk,
  input  logic rst,
  input  logic test_mode_i,
  input  logic freeze_i,
  output logic decay_hit_o,
  output logic decay_evt_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          tick;
  logic          evt_q;

  // Next counter values; test_mode parks the prescaler and ticks every cycle.
  always_comb begin
    tick    = !freeze_i && (test_mode_i || (presc_q == PRESC_LAST));
    presc_d = presc_q;
    if (!freeze_i) begin
      presc_d = (test_mode_i || (presc_q == PRESC_LAST)) ? '0 : presc_q + 1'b1;
    end
    dcnt_d = dcnt_q;
    if (tick) begin
      dcnt_d = (dcnt_q == DECAY_LAST) ? '0 : dcnt_q + 1'b1;
    end
  end

  // Combinational hit lets the top update levels on the same edge the pulse rises.
  assign decay_hit_o = tick && (dcnt_q == DECAY_LAST);
  assign decay_evt_o = evt_q;

  // Counter and decay pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      dcnt_q  <= '0;
      evt_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      dcnt_q  <= dcnt_d;
      evt_q   <= decay_hit_o;
    end
  end

endmodule

// File: rtl/pet_needs_engine.sv
// Need/health engine: need array, health, care-action handshake and the
// ALIVE/SLEEPING/DEAD life cycle.
module pet_needs_engine
  import pet_pkg::*;
#(
  parameter int N_NEEDS     = 5,
  parameter int LEVEL_W     = 3,
  parameter int TICK_DIV    = 50000000,
  parameter int DECAY_TICKS = 900,
  parameter int ACTION_GAIN = 2,
  parameter int HEAL_THRESH = 4,
  parameter int SLEEP_IDX   = NEED_SLEEP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       test_mode_i,
  input  logic                       action_valid_i,
  input  logic [2:0]                 action_id_i,
  output logic                       action_ready_o,
  output logic                       action_err_o,
  output logic [N_NEEDS*LEVEL_W-1:0] levels_o,
  output logic [LEVEL_W-1:0]         health_o,
  output logic [1:0]                 state_o,
  output logic                       dead_o,
  output logic                       decay_evt_o
);
  typedef logic [LEVEL_W-1:0] level_t;
  localparam level_t MAX_L  = '1;
  localparam level_t GAIN_L = level_t'(ACTION_GAIN);
  localparam level_t HEAL_L = level_t'(HEAL_THRESH);
  localparam level_t ONE_L  = level_t'(1);

  level_t     lvl_q [N_NEEDS];
  level_t     lvl_d [N_NEEDS];
  level_t     health_q, health_d;
  pet_state_e state_q;
  logic       ready_q, dead_q, err_q;
  logic       decay_hit, accept, any_zero, all_ok;
  logic [31:0] aid;

  function automatic level_t inc_lvl(input level_t l, input level_t g);
    return level_t'(sat_inc(lvl_t'(l), lvl_t'(g), lvl_t'(MAX_L)));
  endfunction

  function automatic level_t dec_lvl(input level_t l);
    return level_t'(sat_dec(lvl_t'(l)));
  endfunction

  pet_tick_gen #(
    .TICK_DIV    (TICK_DIV),
    .DECAY_TICKS (DECAY_TICKS)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .test_mode_i (test_mode_i),
    .freeze_i    (state_q == ST_DEAD),
    .decay_hit_o (decay_hit),
    .decay_evt_o (decay_evt_o)
  );

  // Next need/health values: decay first, then the accepted action's gain.
  // Health looks at the pre-event need values.
  always_comb begin
    aid      = 32'(action_id_i);
    accept   = action_valid_i && ready_q;
    any_zero = 1'b0;
    all_ok   = 1'b1;
    health_d = health_q;
    for (int i = 0; i < N_NEEDS; i++) begin
      lvl_d[i] = lvl_q[i];
      if (lvl_q[i] == '0)   any_zero = 1'b1;
      if (lvl_q[i] < HEAL_L) all_ok  = 1'b0;
    end
    if (decay_hit) begin
      for (int i = 0; i < N_NEEDS; i++) begin
        if ((state_q == ST_SLEEPING) && (i == SLEEP_IDX)) lvl_d[i] = inc_lvl(lvl_q[i], ONE_L);
        else                                               lvl_d[i] = dec_lvl(lvl_q[i]);
      end
      if (any_zero)                           health_d = dec_lvl(health_q);
      else if (all_ok && (health_q != MAX_L)) health_d = inc_lvl(health_q, ONE_L);
    end
    if (accept && (aid < 32'(N_NEEDS))) begin
      for (int i = 0; i < N_NEEDS; i++) begin
        if (aid == 32'(i)) lvl_d[i] = inc_lvl(lvl_d[i], GAIN_L);
      end
    end
  end

  // Register needs/health and step the life-cycle FSM; death wins over waking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEEDS; i++) lvl_q[i] <= MAX_L;
      health_q <= MAX_L;
      state_q  <= ST_ALIVE;
      ready_q  <= 1'b1;
      dead_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && (aid >= 32'(N_NEEDS));
      if (state_q != ST_DEAD) begin
        for (int i = 0; i < N_NEEDS; i++) lvl_q[i] <= lvl_d[i];
        health_q <= health_d;
      end
      case (state_q)
        ST_ALIVE: begin
          if (health_d == '0) begin
            state_q <= ST_DEAD;
            ready_q <= 1'b0;
            dead_q  <= 1'b1;
          end else if (accept && (aid == 32'(SLEEP_IDX))) begin
            state_q <= ST_SLEEPING;
            ready_q <= 1'b0;
          end
        end
        ST_SLEEPING: begin
          if (health_d == '0) begin
            state_q <= ST_DEAD;
            ready_q <= 1'b0;
            dead_q  <= 1'b1;
          end else if (lvl_d[SLEEP_IDX] == MAX_L) begin
            state_q <= ST_ALIVE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_DEAD;
          ready_q <= 1'b0;
          dead_q  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_NEEDS; g++) begin : g_pack
    assign levels_o[g*LEVEL_W +: LEVEL_W] = lvl_q[g];
  end

  assign health_o       = health_q;
  assign state_o        = state_q;
  assign dead_o         = dead_q;
  assign action_ready_o = ready_q;
  assign action_err_o   = err_q;

endmodule

// File: tb/tb_pet_needs_engine.sv
// Directed bench for pet_needs_engine with TICK_DIV=4, DECAY_TICKS=3
// (decay event every 12 cycles).
module tb_pet_needs_engine;
  import pet_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        test_mode;
  logic        action_valid;
  logic [2:0]  action_id;
  logic        action_ready, action_err, dead, decay_evt;
  logic [14:0] levels;
  logic [2:0]  health;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  pet_needs_engine #(
    .N_NEEDS(5), .LEVEL_W(3), .TICK_DIV(4), .DECAY_TICKS(3),
    .ACTION_GAIN(2), .HEAL_THRESH(4), .SLEEP_IDX(NEED_SLEEP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .test_mode_i    (test_mode),
    .action_valid_i (action_valid),
    .action_id_i    (action_id),
    .action_ready_o (action_ready),
    .action_err_o   (action_err),
    .levels_o       (levels),
    .health_o       (health),
    .state_o        (state),
    .dead_o         (dead),
    .decay_evt_o    (decay_evt)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input int a0, input int a1, input int a2, input int a3, input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; action_valid = 1'b0; action_id = 3'd0; test_mode = 1'b0;
    step(); step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic act(input int id);
    action_valid = 1'b1;
    action_id    = 3'(id);
    step();
    action_valid = 1'b0;
  endtask

  task automatic test_reset();
    int ev;
    rst = 1'b1; action_valid = 1'b0; action_id = 3'd0; test_mode = 1'b0;
    step(); step();
    n_tests++; if (levels !== 15'h7fff) begin n_fail++; $display("FAIL reset_levels: got %h want %h", levels, 15'h7fff); end
    n_tests++; if (health !== 3'd7) begin n_fail++; $display("FAIL reset_health: got %0d want 7", health); end
    n_tests++; if (state !== ST_ALIVE || dead !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0d/%b want 0/0", state, dead); end
    n_tests++; if (action_ready !== 1'b1 || action_err !== 1'b0 || decay_evt !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: rdy/err/evt got %b%b%b want 100", action_ready, action_err, decay_evt); end
    rst = 1'b0; cyc = 0; ev = 0;
    repeat (11) begin step(); if (decay_evt !== 1'b0) ev++; end
    n_tests++; if (ev !== 0) begin n_fail++; $display("FAIL early_decay: got %0d pulses want 0", ev); end
    step();
    n_tests++; if (decay_evt !== 1'b1) begin n_fail++; $display("FAIL first_decay_evt: got %b want 1", decay_evt); end
    n_tests++; if (levels !== pk(6,6,6,6,6)) begin n_fail++; $display("FAIL first_decay_levels: got %h want %h", levels, pk(6,6,6,6,6)); end
  endtask

  task automatic test_idle_death();
    int bad;
    do_reset();
    run_to(84);
    n_tests++; if (levels !== 15'h0 || health !== 3'd7) begin n_fail++; $display("FAIL idle_ev7: lv %h hp %0d want 0000 7", levels, health); end
    run_to(96);
    n_tests++; if (health !== 3'd6) begin n_fail++; $display("FAIL idle_ev8_health: got %0d want 6", health); end
    run_to(132);
    n_tests++; if (health !== 3'd3) begin n_fail++; $display("FAIL idle_ev11_health: got %0d want 3", health); end
    run_to(167);
    n_tests++; if (health !== 3'd1 || state !== ST_ALIVE) begin n_fail++; $display("FAIL pre_death: hp %0d st %0d want 1 0", health, state); end
    step();
    n_tests++; if (health !== 3'd0 || state !== ST_DEAD || dead !== 1'b1 || action_ready !== 1'b0) begin
      n_fail++; $display("FAIL death_edge: hp %0d st %0d dead %b rdy %b want 0 2 1 0", health, state, dead, action_ready); end
    bad = 0;
    action_valid = 1'b1; action_id = 3'(NEED_HUNGER);
    repeat (100) begin
      step();
      if (levels !== 15'h0 || health !== 3'd0 || state !== ST_DEAD || decay_evt !== 1'b0 || action_err !== 1'b0) bad++;
    end
    action_valid = 1'b0;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL dead_frozen: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_action_gain();
    do_reset();
    run_to(12);
    act(NEED_HUNGER);
    n_tests++; if (levels !== pk(7,6,6,6,6)) begin n_fail++; $display("FAIL gain_saturate: got %h want %h", levels, pk(7,6,6,6,6)); end
    run_to(71);
    act(NEED_HUNGER);
    n_tests++; if (decay_evt !== 1'b1 || levels !== pk(4,1,1,1,1)) begin
      n_fail++; $display("FAIL gain_on_decay: evt %b lv %h want 1 %h", decay_evt, levels, pk(4,1,1,1,1)); end
  endtask

  task automatic test_sleep();
    do_reset();
    run_to(49);
    act(NEED_SLEEP);
    n_tests++; if (levels !== pk(3,5,3,3,3) || state !== ST_SLEEPING || action_ready !== 1'b0) begin
      n_fail++; $display("FAIL sleep_enter: lv %h st %0d rdy %b want %h 1 0", levels, state, action_ready, pk(3,5,3,3,3)); end
    action_valid = 1'b1; action_id = 3'(NEED_HUNGER);
    run_to(55);
    action_valid = 1'b0;
    n_tests++; if (levels !== pk(3,5,3,3,3) || action_err !== 1'b0) begin
      n_fail++; $display("FAIL sleep_ignore_valid: lv %h err %b want %h 0", levels, action_err, pk(3,5,3,3,3)); end
    run_to(60);
    n_tests++; if (levels !== pk(2,6,2,2,2) || state !== ST_SLEEPING) begin
      n_fail++; $display("FAIL sleep_recharge: lv %h st %0d want %h 1", levels, state, pk(2,6,2,2,2)); end
    run_to(72);
    n_tests++; if (levels !== pk(1,7,1,1,1) || state !== ST_ALIVE || action_ready !== 1'b1) begin
      n_fail++; $display("FAIL sleep_wake: lv %h st %0d rdy %b want %h 0 1", levels, state, action_ready, pk(1,7,1,1,1)); end
  endtask

  task automatic test_heal_and_err();
    int feed1 [8] = '{NEED_HUNGER, NEED_HUNGER, NEED_HAPPINESS, NEED_HAPPINESS,
                      NEED_HYGIENE, NEED_HYGIENE, NEED_CONDITION, NEED_CONDITION};
    do_reset();
    run_to(72);
    act(NEED_SLEEP);
    n_tests++; if (levels !== pk(1,3,1,1,1) || state !== ST_SLEEPING) begin
      n_fail++; $display("FAIL heal_sleep_enter: lv %h st %0d want %h 1", levels, state, pk(1,3,1,1,1)); end
    run_to(120);
    n_tests++; if (levels !== pk(0,7,0,0,0) || health !== 3'd4 || state !== ST_ALIVE) begin
      n_fail++; $display("FAIL heal_wake: lv %h hp %0d st %0d want %h 4 0", levels, health, state, pk(0,7,0,0,0)); end
    foreach (feed1[k]) act(feed1[k]);
    n_tests++; if (levels !== pk(4,7,4,4,4)) begin n_fail++; $display("FAIL back_to_back: got %h want %h", levels, pk(4,7,4,4,4)); end
    run_to(132);
    n_tests++; if (health !== 3'd5 || levels !== pk(3,6,3,3,3)) begin
      n_fail++; $display("FAIL heal_4to5: hp %0d lv %h want 5 %h", health, levels, pk(3,6,3,3,3)); end
    act(NEED_HUNGER); act(NEED_HAPPINESS); act(NEED_HYGIENE); act(NEED_CONDITION);
    act(6);
    n_tests++; if (action_err !== 1'b1 || levels !== pk(5,6,5,5,5)) begin
      n_fail++; $display("FAIL err_id6: err %b lv %h want 1 %h", action_err, levels, pk(5,6,5,5,5)); end
    step();
    n_tests++; if (action_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_len: got %b want 0", action_err); end
    act(5);
    n_tests++; if (action_err !== 1'b1 || levels !== pk(5,6,5,5,5)) begin
      n_fail++; $display("FAIL err_id5: err %b lv %h want 1 %h", action_err, levels, pk(5,6,5,5,5)); end
    run_to(144);
    n_tests++; if (health !== 3'd6 || levels !== pk(4,5,4,4,4) || state !== ST_ALIVE) begin
      n_fail++; $display("FAIL heal_5to6: hp %0d lv %h st %0d want 6 %h 0", health, levels, state, pk(4,5,4,4,4)); end
  endtask

  task automatic test_rst_mid_and_test_mode();
    logic [8:0] pat;
    do_reset();
    run_to(36);
    act(NEED_SLEEP);
    n_tests++; if (state !== ST_SLEEPING) begin n_fail++; $display("FAIL rst_pre_sleep: got %0d want 1", state); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (levels !== 15'h7fff || health !== 3'd7 || state !== ST_ALIVE || action_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_sleeping: lv %h hp %0d st %0d rdy %b want 7fff 7 0 1", levels, health, state, action_ready); end
    step();
    rst = 1'b0; cyc = 0;
    run_to(168);
    n_tests++; if (state !== ST_DEAD) begin n_fail++; $display("FAIL rst_pre_dead: got %0d want 2", state); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (levels !== 15'h7fff || health !== 3'd7 || state !== ST_ALIVE || dead !== 1'b0 || action_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_dead: lv %h hp %0d st %0d dead %b rdy %b want 7fff 7 0 0 1", levels, health, state, dead, action_ready); end
    step();
    rst = 1'b0; cyc = 0;
    test_mode = 1'b1;
    pat = '0;
    repeat (9) begin step(); pat[cyc-1] = decay_evt; end
    test_mode = 1'b0;
    n_tests++; if (pat !== 9'b100100100) begin n_fail++; $display("FAIL test_mode_evt: got %b want 100100100", pat); end
    n_tests++; if (levels !== pk(4,4,4,4,4) || health !== 3'd7) begin
      n_fail++; $display("FAIL test_mode_levels: lv %h hp %0d want %h 7", levels, health, pk(4,4,4,4,4)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; test_mode = 1'b0; action_valid = 1'b0; action_id = 3'd0;
    test_reset();
    test_idle_death();
    test_action_gain();
    test_sleep();
    test_heal_and_err();
    test_rst_mid_and_test_mode();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
